controller_interface_m: RTL and testbench

Polls two NES-style serial gamepads once per frame and presents their button states to the 6502 as two read-only bytes. The block sits directly downstream of the address decoder in `top_m` and consumes its `SELECT_controller` strobe and the `vblank_irq_B` frame signal. It drives the shared latch and clock pins to both pads. Each poll commits both bytes in one cycle, so a CPU read never returns a half-updated value.

---
 rtl/controller_pkg.sv | 26 ++
 rtl/sync_2ff_m.sv | 28 ++
 rtl/controller_interface_m.sv | 135 +++++++++++++
 tb/tb_controller_interface_m.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared definitions for the gamepad poller: FSM states, button bit
// positions inside a pad byte, and the CPU register offsets of the two pads.
package controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } ctrl_state_t;

    // First serial bit lands in bit 7, last in bit 0. Pressed reads as 1.
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    // Value of cpu_address_lsb that selects each pad.
    localparam logic PAD0_OFS = 1'b0;
    localparam logic PAD1_OFS = 1'b1;

endpackage

// File: rtl/sync_2ff_m.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff_m #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back stages to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/controller_interface_m.sv
// Polls two NES-style serial pads once per frame and exposes their button
// bytes to the CPU. Both pad bytes are committed together in one cycle.
module controller_interface_m
    import controller_pkg::*;
#(
    parameter int DIV = 64
) (
    input  logic       clk_12_5875,
    input  logic       rst_B,
    input  logic       vblank_irq_B,
    input  logic       SELECT_controller,
    input  logic       cpu_address_lsb,
    input  logic [1:0] ctrl_data_B,
    output logic       ctrl_latch,
    output logic       ctrl_clk,
    output logic [7:0] data_out,
    output logic       poll_busy
);

    localparam int            CW      = $clog2(DIV);
    localparam logic [CW-1:0] PH_LAST = CW'(DIV - 1);
    // Capture on the edge that opens the last low cycle of a bit slot.
    localparam logic [CW-1:0] PH_SAMP = CW'(DIV - 2);

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] ph_q, ph_d;
    logic          hi_q, hi_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr0_q, sr0_d, sr1_q, sr1_d;
    logic [7:0]    pad0_q, pad0_d, pad1_q, pad1_d;
    logic          vb_q, vb_d, vb_prev_q, vb_prev_d;
    logic [1:0]    data_sync;

    // Idle pad lines are high (not pressed), so the synchronizer resets to 1s.
    sync_2ff_m #(.W(2), .RST_VAL(2'b11)) u_sync (
        .clk   (clk_12_5875),
        .rst_n (rst_B),
        .d     (ctrl_data_B),
        .q     (data_sync)
    );

    // State register and all datapath flops.
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            hi_q      <= 1'b0;
            bit_q     <= 3'd0;
            sr0_q     <= 8'h00;
            sr1_q     <= 8'h00;
            pad0_q    <= 8'h00;
            pad1_q    <= 8'h00;
            vb_q      <= 1'b1;
            vb_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            hi_q      <= hi_d;
            bit_q     <= bit_d;
            sr0_q     <= sr0_d;
            sr1_q     <= sr1_d;
            pad0_q    <= pad0_d;
            pad1_q    <= pad1_d;
            vb_q      <= vb_d;
            vb_prev_q <= vb_prev_d;
        end
    end

    // Next-state logic: latch pulse, eight clocked bit slots, then one commit.
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        hi_d      = hi_q;
        bit_d     = bit_q;
        sr0_d     = sr0_q;
        sr1_d     = sr1_q;
        pad0_d    = pad0_q;
        pad1_d    = pad1_q;
        vb_d      = vblank_irq_B;
        vb_prev_d = vb_q;
        case (state_q)
            ST_IDLE: begin
                ph_d  = '0;
                hi_d  = 1'b0;
                bit_d = 3'd0;
                // Triggers outside IDLE are simply never looked at.
                if (vb_prev_q && !vb_q) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (ph_q == PH_LAST) begin
                    ph_d    = '0;
                    state_d = ST_SHIFT;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!hi_q && ph_q == PH_SAMP) begin
                    sr0_d = {sr0_q[6:0], ~data_sync[0]};
                    sr1_d = {sr1_q[6:0], ~data_sync[1]};
                end
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (hi_q) begin
                        hi_d = 1'b0;
                        if (bit_q == 3'd7) state_d = ST_COMMIT;
                        else               bit_d   = bit_q + 3'd1;
                    end else begin
                        hi_d = 1'b1;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                pad0_d  = sr0_q;
                pad1_d  = sr1_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ctrl_latch = (state_q == ST_LATCH);
    assign ctrl_clk   = (state_q == ST_SHIFT) && hi_q;
    assign poll_busy  = (state_q != ST_IDLE);

    // CPU read mux; bus floats to zero when the window is not decoded.
    always_comb begin
        data_out = 8'h00;
        if (SELECT_controller)
            data_out = (cpu_address_lsb == PAD1_OFS) ? pad1_q : pad0_q;
    end

endmodule

// File: tb/tb_controller_interface_m.sv
// Directed bench for controller_interface_m with DIV=4 and a live pad model.
module tb_controller_interface_m;

    logic       clk = 1'b0;
    logic       rst_B;
    logic       vblank_irq_B;
    logic       SELECT_controller;
    logic       cpu_address_lsb;
    logic [1:0] ctrl_data_B;
    logic       ctrl_latch;
    logic       ctrl_clk;
    logic [7:0] data_out;
    logic       poll_busy;

    int checks = 0;
    int errors = 0;

    controller_interface_m #(.DIV(4)) dut (
        .clk_12_5875       (clk),
        .rst_B             (rst_B),
        .vblank_irq_B      (vblank_irq_B),
        .SELECT_controller (SELECT_controller),
        .cpu_address_lsb   (cpu_address_lsb),
        .ctrl_data_B       (ctrl_data_B),
        .ctrl_latch        (ctrl_latch),
        .ctrl_clk          (ctrl_clk),
        .data_out          (data_out),
        .poll_busy         (poll_busy)
    );

    always #5 clk = ~clk;

    // Pad model: latch resets the bit pointer, each ctrl_clk rise advances it.
    // Serial output follows the current button state (pressed drives 0).
    logic [7:0] btn0 = 8'h00;
    logic [7:0] btn1 = 8'h00;
    logic [3:0] pidx = 4'd8;
    logic [2:0] sel_bit;
    always @(posedge ctrl_clk or posedge ctrl_latch) begin
        if (ctrl_latch)       pidx <= 4'd0;
        else if (pidx < 4'd8) pidx <= pidx + 4'd1;
    end
    assign sel_bit     = 3'd7 - pidx[2:0];
    assign ctrl_data_B = (pidx < 4'd8) ? ~{btn1[sel_bit], btn0[sel_bit]} : 2'b00;

    // Running totals of latch-high cycles, clk-high cycles and clk pulses.
    int lat_n = 0, clkhi_n = 0, pulse_n = 0;
    always @(negedge clk) begin
        if (ctrl_latch) lat_n   <= lat_n + 1;
        if (ctrl_clk)   clkhi_n <= clkhi_n + 1;
    end
    always @(posedge ctrl_clk) pulse_n <= pulse_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_both(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        cpu_address_lsb = 1'b0; #1;
        chk({tag, "_pad0"}, {24'd0, data_out}, {24'd0, e0});
        cpu_address_lsb = 1'b1; #1;
        chk({tag, "_pad1"}, {24'd0, data_out}, {24'd0, e1});
        cpu_address_lsb = 1'b0;
    endtask

    // One full poll. Called #1 after a posedge; the next posedge is cycle 0.
    task automatic poll(input string tag, input int retrig, input int chg,
                        input logic [7:0] n0, input logic [7:0] n1,
                        input logic [7:0] old0,
                        input logic [7:0] e0, input logic [7:0] e1);
        int l0, c0, p0;
        l0 = lat_n; c0 = clkhi_n; p0 = pulse_n;
        SELECT_controller = 1'b1;
        vblank_irq_B = 1'b0;
        for (int c = 0; c <= 75; c++) begin
            @(posedge clk); #1;
            if (c == 2)          vblank_irq_B = 1'b1;
            if (c == retrig)     vblank_irq_B = 1'b0;
            if (c == retrig + 2) vblank_irq_B = 1'b1;
            if (c == chg) begin btn0 = n0; btn1 = n1; end
            if (c == 0)  chk({tag, "_busy_c0"},  32'(poll_busy),  32'd0);
            if (c == 1) begin
                chk({tag, "_latch_c1"}, 32'(ctrl_latch), 32'd1);
                chk({tag, "_busy_c1"},  32'(poll_busy),  32'd1);
            end
            if (c == 5)  chk({tag, "_latch_c5"}, 32'(ctrl_latch), 32'd0);
            if (c == 69) begin
                chk({tag, "_busy_c69"}, 32'(poll_busy), 32'd1);
                chk({tag, "_old_c69"},  {24'd0, data_out}, {24'd0, old0});
            end
            if (c == 70) begin
                chk({tag, "_busy_c70"}, 32'(poll_busy), 32'd0);
                read_both({tag, "_new"}, e0, e1);
            end
            if (c == 75) begin
                chk({tag, "_busy_c75"},  32'(poll_busy),  32'd0);
                chk({tag, "_latch_c75"}, 32'(ctrl_latch), 32'd0);
            end
        end
        chk({tag, "_latch_cycles"}, 32'(lat_n - l0),     32'd4);
        chk({tag, "_clk_hi_cycles"}, 32'(clkhi_n - c0),  32'd32);
        chk({tag, "_clk_pulses"},   32'(pulse_n - p0),   32'd8);
    endtask

    initial begin
        rst_B = 1'b0;
        vblank_irq_B = 1'b1;
        SELECT_controller = 1'b0;
        cpu_address_lsb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_latch", 32'(ctrl_latch), 32'd0);
        chk("rst_clk",   32'(ctrl_clk),   32'd0);
        chk("rst_busy",  32'(poll_busy),  32'd0);
        SELECT_controller = 1'b1;
        read_both("rst_read", 8'h00, 8'h00);
        rst_B = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Pad 0: A+Right, pad 1: Start.
        btn0 = 8'h81; btn1 = 8'h10;
        poll("p1", -10, -10, 8'h00, 8'h00, 8'h00, 8'h81, 8'h10);

        // Retrigger mid-poll is ignored; new buttons B+Left / Select+Down.
        btn0 = 8'h42; btn1 = 8'h24;
        poll("p2", 29, -10, 8'h00, 8'h00, 8'h81, 8'h42, 8'h24);

        // All pressed, released after bit 3 was sampled.
        btn0 = 8'hFF; btn1 = 8'hFF;
        poll("p3", -10, 34, 8'h00, 8'h00, 8'h42, 8'hF0, 8'hF0);

        // Window not decoded reads zero even with nonzero pads.
        SELECT_controller = 1'b0;
        read_both("nosel", 8'h00, 8'h00);

        // Reset mid-poll with both pads fully pressed.
        SELECT_controller = 1'b1;
        btn0 = 8'hFF; btn1 = 8'hFF;
        vblank_irq_B = 1'b0;
        for (int c = 0; c <= 80; c++) begin
            @(posedge clk); #1;
            if (c == 2)  vblank_irq_B = 1'b1;
            if (c == 39) chk("mid_busy", 32'(poll_busy), 32'd1);
            if (c == 40) begin
                rst_B = 1'b0; #1;
                chk("mrst_latch", 32'(ctrl_latch), 32'd0);
                chk("mrst_clk",   32'(ctrl_clk),   32'd0);
                chk("mrst_busy",  32'(poll_busy),  32'd0);
                read_both("mrst_read", 8'h00, 8'h00);
            end
            if (c == 42) rst_B = 1'b1;
        end
        chk("post_busy", 32'(poll_busy), 32'd0);
        read_both("post_read", 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case something above stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
